// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl
// Sequencer wrapped around a combinational 32-bit unsigned divider for the
// RISC-V M-extension DIV/DIVU/REM/REMU ops. It accepts an op, presents
// registered operand magnitudes to the divider for WAIT_CYCLES cycles,
// captures the divider outputs, applies sign and divide-by-zero fix-ups, and
// holds the tagged result until writeback takes it.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous abort of any in-flight op
//   in_valid/in_ready   op request handshake
//   in_op               00 DIV, 01 DIVU, 10 REM, 11 REMU
//   in_a, in_b, in_tag  dividend, divisor, destination tag
//   div_dividend/div_divisor     magnitudes driven to the divider
//   div_quotient/div_remainder   unsigned divider results
//   div_error           divider zero flag (unused, zero divisor detected here)
//   out_valid/out_ready result handshake
//   out_result, out_tag, out_dz  rd value, tag, divisor-was-zero flag
module div_issue_ctrl #(
  parameter int WAIT_CYCLES = 4,
  parameter int TAG_W       = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      div_dividend,
  output logic [31:0]      div_divisor,
  input  logic [31:0]      div_quotient,
  input  logic [31:0]      div_remainder,
  input  logic             div_error,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dz
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               dz_q, dz_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic [31:0]        a_raw_q, a_raw_d;
  logic [31:0]        dividend_q, dividend_d;
  logic [31:0]        divisor_q, divisor_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        result_q, result_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;
  logic               out_dz_q, out_dz_d;
  logic               signed_op_s;
  logic               unused_div_error_s;

  // Zero-divisor detection is done locally from in_b, so the divider flag is dropped.
  assign unused_div_error_s = div_error;

  // op[0] set means the unsigned variant (DIVU/REMU).
  assign signed_op_s = ~in_op[0];

  // Turns unsigned divider outputs into the architectural rd value.
  // The signed overflow case (INT_MIN / -1) needs no special branch: the
  // magnitude path yields q = 0x80000000, negation leaves it unchanged, r = 0.
  function automatic logic [31:0] fix_result(
    input logic [1:0]  op,
    input logic        dz,
    input logic        sa,
    input logic        sb,
    input logic [31:0] a_raw,
    input logic [31:0] q_mag,
    input logic [31:0] r_mag
  );
    logic [31:0] q;
    logic [31:0] r;
    if (dz) begin
      q = 32'hFFFF_FFFF;
      r = a_raw;
    end else begin
      q = (sa ^ sb) ? (32'd0 - q_mag) : q_mag;
      r = sa ? (32'd0 - r_mag) : r_mag;
    end
    return op[1] ? r : q;
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      op_q        <= 2'd0;
      tag_q       <= '0;
      dz_q        <= 1'b0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      a_raw_q     <= 32'd0;
      dividend_q  <= 32'd0;
      divisor_q   <= 32'd0;
      out_valid_q <= 1'b0;
      result_q    <= 32'd0;
      out_tag_q   <= '0;
      out_dz_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      tag_q       <= tag_d;
      dz_q        <= dz_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      a_raw_q     <= a_raw_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      out_tag_q   <= out_tag_d;
      out_dz_q    <= out_dz_d;
    end
  end

  // Next-state and datapath update; flush overrides every state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    tag_d       = tag_q;
    dz_d        = dz_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    a_raw_d     = a_raw_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    out_tag_d   = out_tag_q;
    out_dz_d    = out_dz_q;

    if (flush) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      cnt_d       = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_d       = in_op;
            tag_d      = in_tag;
            dz_d       = (in_b == 32'd0);
            sa_d       = signed_op_s & in_a[31];
            sb_d       = signed_op_s & in_b[31];
            a_raw_d    = in_a;
            dividend_d = (signed_op_s & in_a[31]) ? (32'd0 - in_a) : in_a;
            divisor_d  = (signed_op_s & in_b[31]) ? (32'd0 - in_b) : in_b;
            cnt_d      = CNT_LOAD;
            state_d    = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            result_d    = fix_result(op_q, dz_q, sa_q, sb_q, a_raw_q,
                                     div_quotient, div_remainder);
            out_tag_d   = tag_q;
            out_dz_d    = dz_q;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            out_valid_d = 1'b1;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          cnt_d       = 4'd0;
        end
      endcase
    end
  end

  // in_ready is forced low while reset is asserted even though state is IDLE.
  assign in_ready     = rst_n & (state_q == ST_IDLE);
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;
  assign out_valid    = out_valid_q;
  assign out_result   = result_q;
  assign out_tag      = out_tag_q;
  assign out_dz       = out_dz_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
module tb_div_issue_ctrl;
  localparam int WAIT_CYCLES = 4;
  localparam int TAG_W       = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_a, in_b;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      div_dividend, div_divisor;
  logic [31:0]      div_quotient, div_remainder;
  logic             div_error;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_dz;

  int checks   = 0;
  int failures = 0;

  div_issue_ctrl #(.WAIT_CYCLES(WAIT_CYCLES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_error(div_error),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .out_dz(out_dz)
  );

  always #5 clk = ~clk;

  // Combinational unsigned divider the block sits around.
  always_comb begin
    if (div_divisor == 32'd0) begin
      div_quotient  = 32'hFFFF_FFFF;
      div_remainder = div_dividend;
      div_error     = 1'b1;
    end else begin
      div_quotient  = div_dividend / div_divisor;
      div_remainder = div_dividend % div_divisor;
      div_error     = 1'b0;
    end
  end

  // Architectural RISC-V M-extension result.
  function automatic logic [31:0] ref_result(input logic [1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] res;
    case (op)
      2'b00: begin
        if (b == 32'd0) res = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = 32'h8000_0000;
        else res = $signed(a) / $signed(b);
      end
      2'b01: res = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      2'b10: begin
        if (b == 32'd0) res = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = 32'd0;
        else res = $signed(a) % $signed(b);
      end
      default: res = (b == 32'd0) ? a : a % b;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] mag(input logic is_signed, input logic [31:0] v);
    return (is_signed && v[31]) ? (32'd0 - v) : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Presents one op at a negedge and lets it be accepted on the next posedge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [TAG_W-1:0] tag);
    @(negedge clk);
    chk("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom; in_op = 2'($urandom);
    chk("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
    chk("div_dividend", div_dividend, mag(~op[0], a));
    chk("div_divisor", div_divisor, mag(~op[0], b));
  endtask

  // Waits for the result, checks it, holds it for 'hold' cycles, then takes it.
  task automatic finish_op(input string name, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [TAG_W-1:0] tag, input int hold);
    int k;
    logic [31:0] exp_res;
    exp_res = ref_result(op, a, b);
    k = 0;
    while (out_valid !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk({name, "_latency"}, k, WAIT_CYCLES);
    if (out_valid !== 1'b1) return;
    chk({name, "_result"}, out_result, exp_res);
    chk({name, "_tag"}, {27'd0, out_tag}, {27'd0, tag});
    chk({name, "_dz"}, {31'd0, out_dz}, {31'd0, (b == 32'd0)});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({name, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({name, "_hold_result"}, out_result, exp_res);
      chk({name, "_hold_tag"}, {27'd0, out_tag}, {27'd0, tag});
      chk({name, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    chk({name, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] tag, input int hold);
    issue(op, a, b, tag);
    finish_op(name, op, a, b, tag, hold);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({name, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({name, "_out_result"}, out_result, 32'd0);
    chk({name, "_out_tag"}, {27'd0, out_tag}, 32'd0);
    chk({name, "_out_dz"}, {31'd0, out_dz}, 32'd0);
    chk({name, "_dividend"}, div_dividend, 32'd0);
    chk({name, "_divisor"}, div_divisor, 32'd0);
  endtask

  typedef struct {
    logic [1:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp;
    logic             exp_dz;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{2'b01, 32'd100,        32'd7,          5'd3,  32'd14,         1'b0};
    vecs[1]  = '{2'b11, 32'd100,        32'd7,          5'd4,  32'd2,          1'b0};
    vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          5'd5,  32'hFFFF_FFFD,  1'b0};
    vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFF,  1'b0};
    vecs[4]  = '{2'b00, 32'd7,          32'hFFFF_FFFE,  5'd7,  32'hFFFF_FFFD,  1'b0};
    vecs[5]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  5'd8,  32'd1,          1'b0};
    vecs[6]  = '{2'b00, 32'd5,          32'd0,          5'd9,  32'hFFFF_FFFF,  1'b1};
    vecs[7]  = '{2'b11, 32'd5,          32'd0,          5'd10, 32'd5,          1'b1};
    vecs[8]  = '{2'b01, 32'hFFFF_FFFF,  32'd1,          5'd11, 32'hFFFF_FFFF,  1'b0};
    vecs[9]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'h8000_0000,  1'b0};
    vecs[10] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'd0,          1'b0};
    vecs[11] = '{2'b10, 32'hFFFF_FFF9,  32'd0,          5'd31, 32'hFFFF_FFF9,  1'b1};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 2'd0;
    in_a = 32'd0; in_b = 32'd0; in_tag = '0; out_ready = 1'b0;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("reset_release_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed table: the table's own expected values are checked by hand
    // here, then the whole op goes through the timed sequence.
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      for (int k = 0; k < WAIT_CYCLES; k++) begin
        @(posedge clk); #1;
      end
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_result", i), out_result, vecs[i].exp);
      chk($sformatf("vec%0d_dz", i), {31'd0, out_dz}, {31'd0, vecs[i].exp_dz});
      chk($sformatf("vec%0d_tag", i), {27'd0, out_tag}, {27'd0, vecs[i].tag});
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk($sformatf("vec%0d_drop", i), {31'd0, out_valid}, 32'd0);
    end

    // Back-pressure: result held for 10 cycles.
    run_op("hold", 2'b01, 32'd100, 32'd7, 5'd3, 10);

    // Flush on the second WAIT cycle.
    issue(2'b00, 32'd1000, 32'd3, 5'd20);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      chk("flush_no_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
    end

    // Flush coincident with in_valid in IDLE: not accepted.
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_op = 2'b01; in_a = 32'd9; in_b = 32'd3;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_blocks_accept", {31'd0, in_ready}, 32'd1);

    // Reset mid-WAIT, then a fresh op.
    issue(2'b10, 32'hFFFF_FF00, 32'd7, 5'd17);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("midreset_release_in_ready", {31'd0, in_ready}, 32'd1);
    run_op("after_reset", 2'b00, 32'hFFFF_FF9C, 32'd7, 5'd21, 0);

    // Randomized ops checked against the architectural model.
    for (int n = 0; n < 60; n++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      int sel;
      op  = 2'($urandom);
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = $urandom_range(1, 15);
      else if (sel == 3) b = 32'hFFFF_FFFF;
      else b = b;
      run_op($sformatf("rand%0d", n), op, a, b, TAG_W'($urandom), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
